// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared constants, fetch FSM state type and instruction
// field helpers for the instruction fetch sequencer.
package ifetch_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int INSTR_W_DEF = 16;

    localparam logic [3:0] OPC_JUMP = 4'd9;
    localparam logic [3:0] OPC_HALT = 4'hF;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        REDIRECT = 2'd2,
        HALT     = 2'd3
    } fetch_state_t;

    function automatic logic [3:0] get_opcode(input logic [15:0] word);
        return word[15:12];
    endfunction

    function automatic logic [7:0] get_offset(input logic [15:0] word);
        return word[7:0];
    endfunction

endpackage

// File: rtl/ifetch_skid.sv
// ifetch_skid: one-entry holding slot for a fetched {instr, pc} pair.
// A push and a pop may happen in the same cycle.
module ifetch_skid #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         full;
    logic [W-1:0] data;

    assign in_ready  = !full || out_ready;
    assign out_valid = full;
    assign out_data  = data;

    // Slot occupancy and payload; a simultaneous pop frees room for the push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full <= 1'b0;
            data <= '0;
        end else begin
            if (in_valid && in_ready) begin
                full <= 1'b1;
                data <= in_data;
            end else if (out_valid && out_ready) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: requesting side of the synchronous instruction-ROM port.
// Issues addresses, captures the returned word one cycle later, resolves
// relative jumps (opcode 9) at capture and hands words to decode.
// Optional feature: define IFETCH_HALT_EN to make opcode 4'hF a HALT.
//
// Handshake: a word transfers to decode on a rising edge where
// instr_valid && instr_ready; instr_valid never waits on instr_ready, and
// while it is high and not accepted instr/instr_pc/opcode hold steady.
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  pc_out,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic [3:0]         opcode,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               halted,
    output fetch_state_t       fetch_state
);

    localparam int SKID_W = INSTR_W + ADDR_W;

    fetch_state_t      state;
    logic              inflight_valid;
    logic [ADDR_W-1:0] inflight_pc;
    logic              discard;

    logic              live;
    logic              accept;
    logic              out_free;
    logic              load_skid;
    logic              load_rom;
    logic              skid_push_req;
    logic              skid_push;
    logic              skid_next_full;
    logic              cap_jump;
    logic              issue;
    logic [ADDR_W-1:0] jump_target;

    logic              skid_valid;
    logic              skid_in_ready;
    logic [SKID_W-1:0] skid_out_data;

    logic              halt_block;
    logic              cap_halt;
    logic              halt_take;

    assign opcode      = get_opcode(instr);
    assign fetch_state = state;

    // Routing of the returning ROM word and the issue decision for this edge.
    always_comb begin
        live           = inflight_valid && !discard;
        accept         = instr_valid && instr_ready;
        out_free       = !instr_valid || accept;
        // The skid word is older than anything coming from the ROM, so it goes first.
        load_skid      = skid_valid && out_free;
        load_rom       = live && out_free && !skid_valid;
        skid_push_req  = live && !load_rom;
        skid_push      = skid_push_req && skid_in_ready;
        skid_next_full = skid_push || (skid_valid && !load_skid);
        cap_jump       = live && (get_opcode(rom_data) == OPC_JUMP);
        jump_target    = inflight_pc + ADDR_W'(get_offset(rom_data));
        // Only issue when the word coming back next cycle is guaranteed a home.
        issue          = !skid_next_full && !halt_block;
    end

`ifdef IFETCH_HALT_EN
    logic halt_pend;

    // HALT capture stops issue; acceptance of the HALT word ends fetching.
    always_comb begin
        cap_halt   = live && (get_opcode(rom_data) == OPC_HALT);
        halt_take  = halt_pend && accept && (get_opcode(instr) == OPC_HALT);
        halt_block = halt_pend || cap_halt || (state == HALT);
    end

    // Pending-halt flag and the sticky halted indication.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halt_pend <= 1'b0;
            halted    <= 1'b0;
        end else begin
            if (cap_halt) begin
                halt_pend <= 1'b1;
            end
            if (halt_take) begin
                halted <= 1'b1;
            end
        end
    end
`else
    assign cap_halt   = 1'b0;
    assign halt_take  = 1'b0;
    assign halt_block = 1'b0;
    assign halted     = 1'b0;
`endif

    ifetch_skid #(
        .W (SKID_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (skid_push_req),
        .in_ready  (skid_in_ready),
        .in_data   ({rom_data, inflight_pc}),
        .out_valid (skid_valid),
        .out_ready (out_free),
        .out_data  (skid_out_data)
    );

    // Fetch FSM with PC, in-flight tracking and the decode output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= BOOT;
            pc_out         <= '0;
            inflight_valid <= 1'b0;
            inflight_pc    <= '0;
            discard        <= 1'b0;
            instr          <= '0;
            instr_pc       <= '0;
            instr_valid    <= 1'b0;
        end else begin
            // Output register
            if (halt_take) begin
                instr_valid <= 1'b0;
            end else if (load_skid) begin
                {instr, instr_pc} <= skid_out_data;
                instr_valid       <= 1'b1;
            end else if (load_rom) begin
                instr       <= rom_data;
                instr_pc    <= inflight_pc;
                instr_valid <= 1'b1;
            end else if (accept) begin
                instr_valid <= 1'b0;
            end

            // The ROM samples pc_out on every edge; only issued reads are tracked.
            inflight_valid <= issue;
            if (issue) begin
                inflight_pc <= pc_out;
            end
            // The word read behind a jump or HALT is on the wrong path.
            discard <= cap_jump || cap_halt;

            if (cap_jump) begin
                pc_out <= jump_target;
            end else if (issue) begin
                pc_out <= pc_out + ADDR_W'(1);
            end

            case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN: begin
                    if (halt_take) begin
                        state <= HALT;
                    end else if (cap_jump) begin
                        state <= REDIRECT;
                    end
                end
                REDIRECT: begin
                    if (halt_take) begin
                        state <= HALT;
                    end else begin
                        state <= RUN;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
            endcase
        end
    end

    // A word headed for the skid slot must always find it free.
    a_skid_room: assert property (@(posedge clk) disable iff (!rst)
        skid_push_req |-> skid_in_ready);

    // A stalled word stays put until decode takes it.
    a_stall_stable: assert property (@(posedge clk) disable iff (!rst)
        (instr_valid && !instr_ready) |=> (instr_valid && $stable(instr_pc) && $stable(instr)));

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench for instr_fetch with a synchronous ROM model.
module tb_instr_fetch;
  import ifetch_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   pc_out;
  logic [15:0]  rom_data;
  logic [15:0]  instr;
  logic [7:0]   instr_pc;
  logic [3:0]   opcode;
  logic         instr_valid;
  logic         instr_ready = 1'b1;
  logic         halted;
  fetch_state_t fetch_state;

  int errors = 0;
  int checks = 0;

  logic [15:0] rom [256];
  logic [7:0]  exp_q[$];
  logic [7:0]  got_pc[$];
  logic [15:0] got_instr[$];

  // clock / reset block
  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom[pc_out];

  instr_fetch #(.ADDR_W(8), .INSTR_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_out      (pc_out),
    .rom_data    (rom_data),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .halted      (halted),
    .fetch_state (fetch_state)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 256; i++) rom[i] = {8'h10, 8'(i)};
    rom[0] = 16'h6881;
    rom[1] = 16'h6082;
    rom[2] = 16'h0883;
    rom[3] = 16'h0884;
  endtask

  // program-order model: the pc sequence decode should see
  task automatic fill_exp();
    logic [7:0] p;
    p = 8'd0;
    exp_q.delete();
    for (int k = 0; k < 256; k++) begin
      exp_q.push_back(p);
      if (rom[p][15:12] == 4'd9) p = p + rom[p][7:0];
      else p = p + 8'd1;
    end
  endtask

  task automatic record_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      instr_ready = 1'b1;
      if (instr_valid && instr_ready) begin
        got_pc.push_back(instr_pc);
        got_instr.push_back(instr);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    instr_ready = 1'b1;
    repeat (3) tick();
    checks++; if (pc_out !== 8'd0) begin errors++; $display("FAIL reset_pc_out: got %0h expected 0", pc_out); end
    checks++; if (instr !== 16'd0) begin errors++; $display("FAIL reset_instr: got %0h expected 0", instr); end
    checks++; if (instr_pc !== 8'd0) begin errors++; $display("FAIL reset_instr_pc: got %0h expected 0", instr_pc); end
    checks++; if (opcode !== 4'd0) begin errors++; $display("FAIL reset_opcode: got %0h expected 0", opcode); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", instr_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b expected 0", halted); end
    checks++; if (fetch_state !== BOOT) begin errors++; $display("FAIL reset_state: got %0d expected %0d", fetch_state, BOOT); end
  endtask

  task automatic test_sequential_jump();
    logic        e_v  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [7:0]  e_pc [8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd7, 8'd8};
    logic [15:0] e_ins[8] = '{16'h6881, 16'h6082, 16'h0883, 16'h0884, 16'h9003, 16'h0, 16'h1007, 16'h1008};
    logic [7:0]  e_po [8] = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd7, 8'd8, 8'd9, 8'd10};
    fill_rom();
    rom[4] = 16'h9003;
    instr_ready = 1'b1;
    do_reset();
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL seq_edge1_valid: got %0b expected 0", instr_valid); end
    checks++; if (pc_out !== 8'd1) begin errors++; $display("FAIL seq_edge1_pc_out: got %0h expected 1", pc_out); end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (instr_valid !== e_v[i]) begin errors++; $display("FAIL seq_valid edge %0d: got %0b expected %0b", i + 2, instr_valid, e_v[i]); end
      checks++; if (pc_out !== e_po[i]) begin errors++; $display("FAIL seq_pc_out edge %0d: got %0h expected %0h", i + 2, pc_out, e_po[i]); end
      if (e_v[i]) begin
        checks++; if (instr_pc !== e_pc[i]) begin errors++; $display("FAIL seq_instr_pc edge %0d: got %0h expected %0h", i + 2, instr_pc, e_pc[i]); end
        checks++; if (instr !== e_ins[i]) begin errors++; $display("FAIL seq_instr edge %0d: got %0h expected %0h", i + 2, instr, e_ins[i]); end
        checks++; if (opcode !== e_ins[i][15:12]) begin errors++; $display("FAIL seq_opcode edge %0d: got %0h expected %0h", i + 2, opcode, e_ins[i][15:12]); end
      end
      if (i == 4) begin
        checks++; if (fetch_state !== REDIRECT) begin errors++; $display("FAIL seq_redirect_state: got %0d expected %0d", fetch_state, REDIRECT); end
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0] e_pc [3] = '{8'd3, 8'd4, 8'd5};
    fill_rom();
    instr_ready = 1'b1;
    do_reset();
    repeat (4) tick();
    checks++; if (instr_pc !== 8'd2 || instr_valid !== 1'b1) begin errors++; $display("FAIL stall_start: got pc %0h valid %0b expected pc 2 valid 1", instr_pc, instr_valid); end
    instr_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'd2 || instr !== 16'h0883) begin
        errors++; $display("FAIL stall_hold cycle %0d: got valid %0b pc %0h instr %0h expected 1 2 0883", c, instr_valid, instr_pc, instr);
      end
      checks++; if (pc_out !== 8'd4) begin errors++; $display("FAIL stall_pc_out cycle %0d: got %0h expected 4", c, pc_out); end
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (instr_valid !== 1'b1 || instr_pc !== e_pc[i]) begin
        errors++; $display("FAIL stall_release %0d: got valid %0b pc %0h expected 1 %0h", i, instr_valid, instr_pc, e_pc[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] e_pc [9] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd250, 8'd4, 8'd255, 8'd0, 8'd1};
    fill_rom();
    rom[3]   = 16'h90F7;
    rom[250] = 16'h900A;
    rom[4]   = 16'h90FB;
    do_reset();
    got_pc.delete();
    got_instr.delete();
    record_cycles(18);
    checks++; if (got_pc.size() < 9) begin errors++; $display("FAIL wrap_count: got %0d expected >= 9", got_pc.size()); end
    else begin
      for (int i = 0; i < 9; i++) begin
        checks++; if (got_pc[i] !== e_pc[i] || got_instr[i] !== rom[e_pc[i]]) begin
          errors++; $display("FAIL wrap_seq %0d: got pc %0h instr %0h expected pc %0h instr %0h", i, got_pc[i], got_instr[i], e_pc[i], rom[e_pc[i]]);
        end
      end
    end
  endtask

  task automatic test_self_loop();
    logic [7:0] e_pc [5] = '{8'd0, 8'd1, 8'd2, 8'd2, 8'd2};
    fill_rom();
    rom[2] = 16'h9000;
    do_reset();
    got_pc.delete();
    got_instr.delete();
    record_cycles(14);
    checks++; if (got_pc.size() < 5) begin errors++; $display("FAIL loop_count: got %0d expected >= 5", got_pc.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (got_pc[i] !== e_pc[i]) begin errors++; $display("FAIL loop_seq %0d: got %0h expected %0h", i, got_pc[i], e_pc[i]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        hold;
    logic [7:0]  hpc;
    logic [15:0] hins;
    fill_rom();
    rom[5]  = 16'h9010;
    rom[25] = 16'h90E0;
    fill_exp();
    do_reset();
    got_pc.delete();
    got_instr.delete();
    for (int c = 0; c < 300; c++) begin
      instr_ready = 1'($urandom_range(0, 1));
      hold = instr_valid && !instr_ready;
      hpc  = instr_pc;
      hins = instr;
      if (instr_valid && instr_ready) begin
        got_pc.push_back(instr_pc);
        got_instr.push_back(instr);
      end
      tick();
      if (hold) begin
        checks++; if (instr_valid !== 1'b1 || instr_pc !== hpc || instr !== hins) begin
          errors++; $display("FAIL b2b_stable cycle %0d: got valid %0b pc %0h instr %0h expected 1 %0h %0h", c, instr_valid, instr_pc, instr, hpc, hins);
        end
      end
    end
    checks++; if (got_pc.size() < 40) begin errors++; $display("FAIL b2b_count: got %0d expected >= 40", got_pc.size()); end
    for (int i = 0; i < got_pc.size(); i++) begin
      checks++; if (got_pc[i] !== exp_q[i] || got_instr[i] !== rom[exp_q[i]]) begin
        errors++; $display("FAIL b2b_seq %0d: got pc %0h instr %0h expected pc %0h instr %0h", i, got_pc[i], got_instr[i], exp_q[i], rom[exp_q[i]]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e_pc [4] = '{8'd0, 8'd1, 8'd2, 8'd3};
    fill_rom();
    do_reset();
    for (int c = 0; c < 9; c++) begin
      instr_ready = 1'(c % 2);
      tick();
    end
    rst = 1'b0;
    #1;
    checks++; if (pc_out !== 8'd0 || instr_valid !== 1'b0 || instr !== 16'd0 || instr_pc !== 8'd0 || opcode !== 4'd0) begin
      errors++; $display("FAIL midrst_outputs: got pc_out %0h valid %0b instr %0h pc %0h opc %0h expected all 0", pc_out, instr_valid, instr, instr_pc, opcode);
    end
    checks++; if (fetch_state !== BOOT) begin errors++; $display("FAIL midrst_state: got %0d expected %0d", fetch_state, BOOT); end
    tick();
    rst = 1'b1;
    got_pc.delete();
    got_instr.delete();
    record_cycles(8);
    checks++; if (got_pc.size() < 4) begin errors++; $display("FAIL midrst_count: got %0d expected >= 4", got_pc.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (got_pc[i] !== e_pc[i]) begin errors++; $display("FAIL midrst_seq %0d: got %0h expected %0h", i, got_pc[i], e_pc[i]); end
      end
    end
  endtask

  task automatic test_halt();
    fill_rom();
    rom[6] = 16'hF000;
    instr_ready = 1'b1;
    do_reset();
    repeat (8) tick();
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'd6 || opcode !== 4'hF) begin
      errors++; $display("FAIL halt_word: got valid %0b pc %0h opc %0h expected 1 6 f", instr_valid, instr_pc, opcode);
    end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_early: got %0b expected 0", halted); end
    tick();
`ifdef IFETCH_HALT_EN
    for (int c = 0; c < 20; c++) begin
      checks++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin
        errors++; $display("FAIL halt_hold cycle %0d: got halted %0b valid %0b expected 1 0", c, halted, instr_valid);
      end
      tick();
    end
    checks++; if (fetch_state !== HALT) begin errors++; $display("FAIL halt_state: got %0d expected %0d", fetch_state, HALT); end
`else
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'd7) begin
      errors++; $display("FAIL nohalt_next: got valid %0b pc %0h expected 1 7", instr_valid, instr_pc);
    end
    tick();
    checks++; if (halted !== 1'b0 || instr_pc !== 8'd8) begin
      errors++; $display("FAIL nohalt_follow: got halted %0b pc %0h expected 0 8", halted, instr_pc);
    end
`endif
  endtask

  // scenario sequence and final report
  initial begin
    fill_rom();
    test_reset();
    test_sequential_jump();
    test_stall();
    test_wrap();
    test_self_loop();
    test_back_to_back();
    test_reset_mid();
    test_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch sequencer: the requesting side of the instruction-memory read port. Generates the 8-bit program address into the synchronous instruction ROM and captures the returned 16-bit word one cycle later. Resolves relative jumps (opcode 9) in the fetch stage and delivers instructions to decode over a valid/ready handshake, buffering one word so a decode stall never loses an in-flight read.

## Interface
Parameters:
- ADDR_W, 8, program address width (256-word ROM)
- INSTR_W, 16, instruction width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- pc_out  out  ADDR_W  address driven to ROM; ROM samples it each rising edge
- rom_data  in  INSTR_W  ROM read data for the address sampled at the previous edge
- instr  out  INSTR_W  instruction presented to decode
- instr_pc  out  ADDR_W  address `instr` was fetched from
- opcode  out  4  instr[15:12]
- instr_valid  out  1  instr/instr_pc/opcode valid
- instr_ready  in  1  decode accepts when instr_valid && instr_ready
- halted  out  1  fetch permanently stopped (IFETCH_HALT_EN only; else tied 0)

## Operation
- Instruction fields: opcode = word[15:12]; jump offset = word[7:0], unsigned.
- Jump: opcode 4'd9 ⇒ target = (address of jump word + offset) mod 256. The jump word itself is still delivered to decode.
- Internal tracking: `inflight_valid` + `inflight_pc` identify whether `rom_data` this cycle belongs to an issued address; `discard` marks an in-flight word as dead.
- Issue rule: a new address is issued (pc_out advances) only when the skid slot is empty. When not issuing, pc_out holds and `inflight_valid` is cleared for the re-read.
- Capture rule: a live rom_data word goes to the output register if it is empty or being accepted this cycle; otherwise it goes to the skid slot. When an accepted output word leaves, the skid word moves to the output.
- FSM:
  - BOOT: first cycle after reset release. ROM samples address 0, pc_out ← 1. Next state: RUN.
  - RUN: sequential issue, pc_out ← pc_out + 1 (8-bit wrap, 255 → 0). A captured live jump sets pc_out ← target and marks the in-flight word discard. Next state: REDIRECT.
  - REDIRECT: the discarded word is dropped, and the ROM samples target. Next state: RUN.
  - HALT: see Configuration.
- Jump word captured in the skid path (stall): the redirect is still applied at capture. The discard applies regardless of stall.
- Jump whose target equals its own address (offset 0): legal, loops forever.
- Reset mid-operation: all state cleared asynchronously, in-flight and skid contents lost.

## Timing
- Reset values: pc_out=0, instr=0, instr_pc=0, opcode=0, instr_valid=0, halted=0, FSM=BOOT, skid empty, inflight_valid=0.
- ROM read latency is 1 cycle, and fetch-to-decode latency is 2 edges from address issue.
- First instr_valid (ROM[0]) after the 2nd rising edge following reset release.
- Sustained throughput is 1 instruction/cycle with instr_ready held high.
- Taken jump: 1 bubble cycle. The jump word is valid at edge n, and the target word is valid at edge n+2.
- With instr_ready low, instr/instr_pc/opcode are stable and instr_valid stays high. At most 1 extra word is buffered, and issue resumes the cycle after the skid drains.

## Configuration
- IFETCH_HALT_EN defined: opcode 4'hF is HALT.
  - On capture: stop issuing and discard the in-flight word.
  - The HALT word is delivered normally.
  - After it is accepted: FSM=HALT, halted=1, instr_valid=0.
  - Exit only by reset.
- IFETCH_HALT_EN undefined: opcode 4'hF is an ordinary sequential instruction, no HALT state, halted tied 0.

## Structure
- Package ifetch_pkg:
  - OPC_JUMP=4'd9, OPC_HALT=4'hF
  - ADDR_W/INSTR_W defaults
  - fetch state enum {BOOT, RUN, REDIRECT, HALT}
  - field-extract helpers for opcode and offset
- Sub-module ifetch_skid: 1-entry skid buffer carrying {instr, pc} with valid/ready on both sides. The top level holds the FSM, PC, and in-flight tracking.

## Test plan
- Reset, then ROM[0..3] = 16'h6881, 16'h6082, 16'h0883, 16'h0884, ready=1: instr_pc = 0,1,2,3 on consecutive cycles, with the first valid at edge 2.
- ROM[4] = 16'h9003 (jump +3), ready=1: deliver pc 4, one bubble, then pc 7. ROM[5] is never delivered.
- Hold ready=0 for 5 cycles mid-stream at pc 2: instr stays pc 2 and pc_out stops advancing. After release: 2,3,4 are delivered with no loss or duplicate.
- Jump at pc 250 with offset 8'h0A: next delivered pc is 4 (wrap). Sequential from pc 255: next pc is 0.
- Drop rst low for 1 cycle mid-stream with ready toggling: outputs return to reset values immediately, and the stream restarts at pc 0.
- IFETCH_HALT_EN, ROM[6] = 16'hF000: pc 6 is delivered, then halted=1 and instr_valid=0 held for 20 cycles. Without the macro: pc 7 follows.
